pc_report_tx: RTL and testbench
===============================

Name: pc_report_tx

Overview:
Transmit side of the PC link, in the opposite direction to the PC command parser. Captures a snapshot of the test-result statistics (error count and min/max/average latency, throughput) on request. Serialises the snapshot into a checksummed byte frame toward the PC over a valid/ready byte stream. Sits between the result analyzer / test FSM and the PC communication interface.

Parameters:
HDR_BYTE, 8'hA5, frame start byte
FRAME_TYPE, 8'h52, frame type byte (result report)
TIMEOUT_CYCLES, 1024, consecutive stalled cycles before abort; 0 disables timeout

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
report_req  input  1  single-cycle request to send a report
error_count  input  16  error count to snapshot
min_latency  input  32  statistic to snapshot
max_latency  input  32  statistic to snapshot
average_latency  input  32  statistic to snapshot
throughput  input  32  statistic to snapshot
pc_rsp_valid  output  1  byte on pc_rsp_data is valid
pc_rsp_data  output  8  response byte
pc_rsp_ready  input  1  PC side accepts byte when high together with valid
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse after checksum byte accepted
tx_abort  output  1  one-cycle pulse on timeout abort
drop_count  output  8  saturating count of ignored requests

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- While rst is high: pc_rsp_valid=0, pc_rsp_data=0, busy=0, tx_done=0, tx_abort=0, drop_count=0, state=IDLE, snapshot and checksum registers=0.
- Frame is 22 bytes, in this order:
  - HDR_BYTE
  - FRAME_TYPE
  - LEN = 8'd18
  - 18 payload bytes: error_count[15:8], error_count[7:0], then min, max, average, throughput, each big-endian MSB byte first
  - CSUM
- CSUM = 8-bit sum modulo 256 of TYPE, LEN and all 18 payload bytes. HDR_BYTE is excluded.
- States: IDLE -> HDR -> TYPE -> LEN -> PAYLOAD (byte index 0..17) -> CSUM -> IDLE.
- IDLE:
  - On report_req=1, all five statistic inputs are registered into the snapshot on that edge.
  - State moves to HDR. busy=1 and pc_rsp_valid=1 from the next cycle.
  - Later input changes do not affect the frame in progress.
- Handshake:
  - A byte is transferred on a cycle where pc_rsp_valid && pc_rsp_ready.
  - After a transfer, the next byte is presented on the following cycle with no bubble.
  - While pc_rsp_valid=1 and ready=0, pc_rsp_data holds stable and valid stays high. There is no retraction except abort or rst.
- With ready held high, a frame takes exactly 22 consecutive valid cycles. tx_done pulses on the cycle after the CSUM transfer; busy=0 and pc_rsp_valid=0 on that same cycle.
- Checksum is accumulated incrementally as bytes are transferred. It is cleared on entry to HDR.
- Requests while busy=1, including the cycle of the CSUM transfer:
  - The request is ignored and drop_count increments.
  - drop_count saturates at 8'hFF.
  - No queueing.
- Timeout: a stall counter increments each cycle with valid=1 and ready=0, and clears on any transfer.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero): tx_abort pulses for one cycle, valid drops that cycle, state returns to IDLE, and no tx_done is issued.
  - A report_req on the abort cycle is counted as dropped.
- A report_req in IDLE on the same cycle as tx_done or tx_abort is accepted normally.
- pc_rsp_data = 0 whenever pc_rsp_valid = 0.
- rst asserted mid-frame: immediate return to reset values. The partial frame is not resumed.

Test Plan:
- Basic frame, ready held high:
  - Stimulus: report_req with error_count=16'h0003, min=32'h10, max=32'h100, avg=32'h20, throughput=32'h12345678.
  - Response: 22 bytes A5 52 12 00 03 00 00 00 10 00 00 01 00 00 00 00 20 12 34 56 78 AC; tx_done 1 cycle after byte 22.
- Backpressure:
  - Stimulus: same frame, ready toggled 0/1 each cycle and held low 5 cycles at byte 10.
  - Response: identical byte sequence; data stable during stalls; tx_done after 22nd transfer.
- Snapshot isolation:
  - Stimulus: change all statistic inputs to 32'hFFFFFFFF one cycle after report_req.
  - Response: frame still carries the original values and CSUM AC.
- Dropped requests:
  - Stimulus: 3 report_req pulses mid-frame, plus 1 on the CSUM transfer cycle.
  - Response: drop_count=4; exactly one frame sent.
  - Stimulus: 300 requests while stalled with TIMEOUT_CYCLES=0.
  - Response: drop_count saturates at FF.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, ready stuck low after byte 3.
  - Response: tx_abort pulse after 8 stalled cycles; valid=0; busy=0; no tx_done; next report_req starts a fresh frame with A5.
- Reset mid-frame:
  - Stimulus: assert rst during payload byte 7.
  - Response: all outputs 0 asynchronously; after release, idle until report_req.

Source files
------------

// File: rtl/pc_report_tx_if.sv
// Byte stream from the report transmitter toward the PC link.
// The master drives valid/data; the slave returns ready.
interface pc_report_tx_if;
  logic       pc_rsp_valid;
  logic [7:0] pc_rsp_data;
  logic       pc_rsp_ready;

  modport master (output pc_rsp_valid, output pc_rsp_data, input pc_rsp_ready);
  modport slave  (input pc_rsp_valid, input pc_rsp_data, output pc_rsp_ready);
endinterface

// File: rtl/pc_report_tx.sv
// Snapshots test-result statistics on request and streams them to the PC
// as a 22-byte checksummed frame over a valid/ready byte interface.
module pc_report_tx #(
  parameter logic [7:0]  HDR_BYTE       = 8'hA5,
  parameter logic [7:0]  FRAME_TYPE     = 8'h52,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  report_req,
  input  logic [15:0]           error_count,
  input  logic [31:0]           min_latency,
  input  logic [31:0]           max_latency,
  input  logic [31:0]           average_latency,
  input  logic [31:0]           throughput,
  pc_report_tx_if.master        pc_rsp,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_abort,
  output logic [7:0]            drop_count
);

  localparam int unsigned PAYLOAD_BYTES = 18;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned STALL_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]         LEN_BYTE   = 8'(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TYPE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic [PAYLOAD_BYTES-1:0][7:0]   snap;
  logic [7:0]                      csum;
  logic [STALL_W-1:0]              stall_cnt;
  logic                            valid_c;
  logic [7:0]                      data_c;
  logic                            xfer;
  logic                            stalled;
  logic                            timeout_hit;
  logic                            accept;

  assign xfer        = valid_c && pc_rsp.pc_rsp_ready;
  assign stalled     = valid_c && !pc_rsp.pc_rsp_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && stalled && (stall_cnt == STALL_LAST);
  assign accept      = (state == S_IDLE) && report_req;

  assign pc_rsp.pc_rsp_valid = valid_c;
  assign pc_rsp.pc_rsp_data  = data_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a timeout overrides any progress
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (report_req) state_nxt = S_HDR;
      S_HDR:     if (xfer) state_nxt = S_TYPE;
      S_TYPE:    if (xfer) state_nxt = S_LEN;
      S_LEN:     if (xfer) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (xfer && (idx == IDX_LAST)) state_nxt = S_CSUM;
      S_CSUM:    if (xfer) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (timeout_hit) state_nxt = S_IDLE;
  end

  // Output decode: every non-idle state presents exactly one byte
  always_comb begin
    valid_c = 1'b0;
    data_c  = 8'h00;
    busy    = 1'b0;
    unique case (state)
      S_IDLE:    data_c = 8'h00;
      S_HDR:     data_c = HDR_BYTE;
      S_TYPE:    data_c = FRAME_TYPE;
      S_LEN:     data_c = LEN_BYTE;
      S_PAYLOAD: data_c = snap[IDX_LAST - idx];
      S_CSUM:    data_c = csum;
      default:   data_c = 8'h00;
    endcase
    busy    = (state != S_IDLE);
    valid_c = busy;
  end

  // Snapshot, payload index and running checksum (HDR excluded)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      idx  <= '0;
      csum <= 8'h00;
    end else begin
      if (accept) begin
        snap <= {error_count, min_latency, max_latency, average_latency, throughput};
        csum <= 8'h00;
      end else if (xfer && (state inside {S_TYPE, S_LEN, S_PAYLOAD})) begin
        csum <= csum + data_c;
      end
      if (state != S_PAYLOAD)   idx <= '0;
      else if (xfer)            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Stall counter for the abort timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stall_cnt <= '0;
    else if (!stalled || timeout_hit)       stall_cnt <= '0;
    else if (TIMEOUT_CYCLES != 0)           stall_cnt <= stall_cnt + STALL_W'(1);
  end

  // Status pulses and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      tx_done  <= (state == S_CSUM) && xfer;
      tx_abort <= timeout_hit;
      if (report_req && busy && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_pc_report_tx.sv
// Directed scoreboard bench for pc_report_tx: expected frame bytes are queued
// when a request is issued and popped as the DUT transfers them.
module tb_pc_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2;
  logic [15:0] ec;
  logic [31:0] mn, mx, av, th;
  logic        busy, tx_done, tx_abort;
  logic [7:0]  drop_count;
  logic        busy2, tx_done2, tx_abort2;
  logic [7:0]  drop_count2;

  pc_report_tx_if bus ();
  pc_report_tx_if bus2 ();

  always #5 clk = ~clk;

  pc_report_tx #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .report_req(req),
    .error_count(ec), .min_latency(mn), .max_latency(mx),
    .average_latency(av), .throughput(th),
    .pc_rsp(bus),
    .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort), .drop_count(drop_count)
  );

  pc_report_tx #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst), .report_req(req2),
    .error_count(ec), .min_latency(mn), .max_latency(mx),
    .average_latency(av), .throughput(th),
    .pc_rsp(bus2),
    .busy(busy2), .tx_done(tx_done2), .tx_abort(tx_abort2), .drop_count(drop_count2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];
  logic        done_exp = 1'b0;
  logic        abort_exp = 1'b0;
  logic        done_seen = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  int          fx = 0;
  int          vcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] e, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    logic [143:0] p;
    logic [7:0]   cs;
    logic [7:0]   by;
    p  = {e, a, b, c, d};
    cs = 8'h52 + 8'd18;
    q.push_back(8'hA5);
    q.push_back(8'h52);
    q.push_back(8'd18);
    for (int i = 0; i < 18; i++) begin
      by = p[143 - 8*i -: 8];
      q.push_back(by);
      cs = cs + by;
    end
    q.push_back(cs);
  endtask

  task automatic push_basic();
    logic [7:0] basic [22] = '{8'hA5, 8'h52, 8'h12, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                               8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h20, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAC};
    for (int i = 0; i < 22; i++) q.push_back(basic[i]);
  endtask

  task automatic set_stats(input logic [15:0] e, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    ec = e; mn = a; mx = b; av = c; th = d;
  endtask

  // One cycle: sample and score at negedge, then return just after the next posedge
  task automatic tick();
    logic [31:0] expb;
    @(negedge clk);
    chk("tx_done", 32'(tx_done), 32'(done_exp));
    chk("tx_abort", 32'(tx_abort), 32'(abort_exp));
    if (done_exp || abort_exp) begin
      chk("end_valid", 32'(bus.pc_rsp_valid), 0);
      chk("end_busy", 32'(busy), 0);
    end
    if (!bus.pc_rsp_valid) chk("data_zero", 32'(bus.pc_rsp_data), 0);
    else if (stall_prev)   chk("data_stable", 32'(bus.pc_rsp_data), 32'(stall_data));
    if (tx_done) done_seen = 1'b1;
    done_exp = 1'b0;
    if (bus.pc_rsp_valid) vcnt++;
    if (bus.pc_rsp_valid && bus.pc_rsp_ready) begin
      expb = (q.size() > 0) ? 32'(q.pop_front()) : 32'hFFFF_FFFF;
      chk("byte", 32'(bus.pc_rsp_data), expb);
      fx++;
      if (q.size() == 0) done_exp = 1'b1;
    end
    stall_prev = bus.pc_rsp_valid && !bus.pc_rsp_ready;
    stall_data = bus.pc_rsp_data;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; mode 2: ready toggling with a 5-cycle hold at byte 10
  task automatic run_frame(input int mode, input bit drops, input bit corrupt);
    bit ph = 1'b0;
    bit held = 1'b0;
    int hold = 0;
    fx = 0; vcnt = 0; done_seen = 1'b0;
    req = 1'b1;
    bus.pc_rsp_ready = (mode == 0);
    tick();
    req = 1'b0;
    if (corrupt) set_stats(16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 0; c < 300 && !done_seen; c++) begin
      req = drops && (fx == 3 || fx == 8 || fx == 12 || fx == 21);
      if (mode == 0) begin
        bus.pc_rsp_ready = 1'b1;
      end else begin
        if (fx == 9 && !held) begin hold = 5; held = 1'b1; end
        if (hold > 0) begin bus.pc_rsp_ready = 1'b0; hold--; end
        else begin bus.pc_rsp_ready = ph; ph = ~ph; end
      end
      tick();
    end
    req = 1'b0;
    chk("frame_done", 32'(done_seen), 1);
    chk("frame_xfers", 32'(fx), 22);
    if (mode == 0) chk("frame_cycles", 32'(vcnt), 22);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0;
    bus.pc_rsp_ready = 1'b0;
    bus2.pc_rsp_ready = 1'b0;
    set_stats(16'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus.pc_rsp_valid), 0);
    chk("rst_data", 32'(bus.pc_rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_abort", 32'(tx_abort), 0);
    chk("rst_drop", 32'(drop_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Basic frame with ready high
    set_stats(16'h0003, 32'h10, 32'h100, 32'h20, 32'h1234_5678);
    push_basic();
    run_frame(0, 1'b0, 1'b0);

    // Backpressure
    push_basic();
    run_frame(2, 1'b0, 1'b0);

    // Snapshot isolation
    set_stats(16'h0003, 32'h10, 32'h100, 32'h20, 32'h1234_5678);
    push_basic();
    run_frame(0, 1'b0, 1'b1);

    // Dropped requests, including one on the checksum transfer cycle
    set_stats(16'($urandom), $urandom, $urandom, $urandom, $urandom);
    push_frame(ec, mn, mx, av, th);
    run_frame(0, 1'b1, 1'b0);
    chk("drop_four", 32'(drop_count), 4);
    vcnt = 0;
    bus.pc_rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("one_frame_only", 32'(vcnt), 0);

    // Timeout after 8 stalled cycles; request on the last stalled cycle is dropped
    set_stats(16'($urandom), $urandom, $urandom, $urandom, $urandom);
    push_frame(ec, mn, mx, av, th);
    fx = 0;
    req = 1'b1; bus.pc_rsp_ready = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 20 && fx < 3; c++) tick();
    chk("pre_stall_xfers", 32'(fx), 3);
    bus.pc_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = (i == 7);
      tick();
    end
    req = 1'b0;
    abort_exp = 1'b1;
    tick();
    abort_exp = 1'b0;
    q.delete();
    chk("drop_after_abort", 32'(drop_count), 5);
    vcnt = 0;
    bus.pc_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_after_abort", 32'(vcnt), 0);
    set_stats(16'($urandom), $urandom, $urandom, $urandom, $urandom);
    push_frame(ec, mn, mx, av, th);
    run_frame(0, 1'b0, 1'b0);

    // Reset during payload byte 7
    set_stats(16'($urandom), $urandom, $urandom, $urandom, $urandom);
    push_frame(ec, mn, mx, av, th);
    fx = 0;
    req = 1'b1; bus.pc_rsp_ready = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 30 && fx < 10; c++) tick();
    chk("pre_rst_xfers", 32'(fx), 10);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.pc_rsp_valid), 0);
    chk("arst_data", 32'(bus.pc_rsp_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_drop", 32'(drop_count), 0);
    q.delete();
    stall_prev = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_after_rst", 32'(vcnt), 0);
    set_stats(16'($urandom), $urandom, $urandom, $urandom, $urandom);
    push_frame(ec, mn, mx, av, th);
    run_frame(0, 1'b0, 1'b0);

    // Drop counter saturation with timeout disabled and ready stuck low
    req2 = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) tick();
    chk("drop_100", 32'(drop_count2), 100);
    for (int i = 0; i < 200; i++) tick();
    req2 = 1'b0;
    chk("drop_sat", 32'(drop_count2), 32'hFF);
    chk("nt_valid", 32'(bus2.pc_rsp_valid), 1);
    chk("nt_data", 32'(bus2.pc_rsp_data), 32'hA5);
    chk("nt_abort", 32'(tx_abort2), 0);
    chk("nt_done", 32'(tx_done2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
